irq_ctrl: RTL

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl_pkg.sv | 25 ++
 rtl/irq_arb.sv | 50 +++++
 rtl/irq_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt/trap controller.
//   state_e        : controller FSM encoding
//   ECALL_CAUSE    : mcause value reported for an environment call
//   IRQ_CAUSE_OFF  : mcause / vector offset of interrupt source 0
//   MTVEC_*        : mtvec[1:0] mode encodings
//   idx_width()    : index width for a given source count (min 1 bit)
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  localparam int ECALL_CAUSE   = 11;
  localparam int IRQ_CAUSE_OFF = 16;

  localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_arb.sv
// Interrupt arbiter: picks one source out of the masked pending vector.
//   req_i   : pending & enable vector
//   ptr_i   : index granted last (round-robin start point is ptr_i+1)
//   grant_o : one-hot grant
//   idx_o   : binary index of the granted source
//   valid_o : at least one request present
module irq_arb
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter bit RR_EN   = 1'b0,
  parameter int IW      = idx_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_SRC-1:0] grant_o,
  output logic [IW-1:0]      idx_o,
  output logic               valid_o
);

  // Each request gets a distance from the search start; the smallest wins.
  // Fixed mode: distance is the index itself, so the lowest index wins.
  always_comb begin
    int best_d;
    int best_i;
    int d;
    best_d  = NUM_SRC;
    best_i  = 0;
    d       = 0;
    grant_o = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (RR_EN) begin
        d = i - int'(ptr_i) - 1;
        if (d < 0) d = d + NUM_SRC;
      end else begin
        d = i;
      end
      if (req_i[i] && (d < best_d)) begin
        best_d = d;
        best_i = i;
      end
    end
    valid_o = |req_i;
    idx_o   = IW'(best_i);
    for (int i = 0; i < NUM_SRC; i++) begin
      grant_o[i] = valid_o && (best_i == i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Machine-mode trap/interrupt controller: collects interrupt lines, arbitrates,
// and raises trap requests (exceptions, ECALL, interrupts) and MRET redirects.
//   clk_i, rst_i (async, active low)
//   irq_i          : raw interrupt lines (registered once here)
//   exception_i    : exception cause, nonzero = exception this cycle
//   ecall_i/mret_i : decoded strobes
//   mstatus_mie_i, mie_i, mtvec_i, mepc_i : CSR values
//   trap_ack_i     : pipeline took the redirect
//   trap_req_o, trap_addr_o, trap_cause_o, redirect_o, pending_o
//
// state      | meaning
// ST_IDLE    | running; exceptions, ECALL, interrupts and MRET accepted
// ST_REQ     | trap presented, address/cause frozen until trap_ack_i
// ST_SERVICE | in handler; interrupts masked, MRET returns to IDLE
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int                 NUM_SRC    = 8,
  parameter int                 ADDR_WIDTH = 32,
  parameter logic [NUM_SRC-1:0] EDGE_MASK  = '0,
  parameter bit                 RR_EN      = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_SRC-1:0]    irq_i,
  input  logic [ADDR_WIDTH-1:0] exception_i,
  input  logic                  ecall_i,
  input  logic                  mret_i,
  input  logic                  mstatus_mie_i,
  input  logic [NUM_SRC-1:0]    mie_i,
  input  logic [ADDR_WIDTH-1:0] mtvec_i,
  input  logic [ADDR_WIDTH-1:0] mepc_i,
  input  logic                  trap_ack_i,
  output logic                  trap_req_o,
  output logic [ADDR_WIDTH-1:0] trap_addr_o,
  output logic [ADDR_WIDTH-1:0] trap_cause_o,
  output logic                  redirect_o,
  output logic [NUM_SRC-1:0]    pending_o
);

  localparam int AW = ADDR_WIDTH;
  localparam int IW = idx_width(NUM_SRC);

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] irq_q, irq_prev_q, edge_pend_q, edge_pend_d;
  logic [NUM_SRC-1:0] rise, pending_vec, ack_clr;
  logic [NUM_SRC-1:0] arb_grant, grant_q, grant_d;
  logic [IW-1:0]      arb_idx, idx_q, idx_d, ptr_q, ptr_d;
  logic               arb_valid;
  logic [AW-1:0]      addr_q, addr_d, cause_q, cause_d;
  logic [AW-1:0]      mtvec_base, irq_addr, irq_cause;
  logic               is_irq_q, is_irq_d, redirect_q, redirect_d;

  // Edge sources: a fresh registered rise counts as pending in the same cycle
  // so edge and level sources see the same request latency.
  assign rise        = irq_q & ~irq_prev_q;
  assign pending_vec = (EDGE_MASK & (edge_pend_q | rise)) | (~EDGE_MASK & irq_q);
  assign ack_clr     = (state_q == ST_REQ && trap_ack_i && is_irq_q) ? grant_q : '0;
  // A new edge in the ack cycle keeps the bit set.
  assign edge_pend_d = ((edge_pend_q & ~ack_clr) | rise) & EDGE_MASK;

  irq_arb #(
    .NUM_SRC (NUM_SRC),
    .RR_EN   (RR_EN),
    .IW      (IW)
  ) u_arb (
    .req_i   (pending_vec & mie_i),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign mtvec_base = {mtvec_i[AW-1:2], 2'b00};
  assign irq_cause  = {1'b1, (AW-1)'(IRQ_CAUSE_OFF + int'(arb_idx))};

  // Reserved modes 2/3 fall back to direct.
  always_comb begin
    case (mtvec_i[1:0])
      MTVEC_DIRECT:   irq_addr = mtvec_base;
      MTVEC_VECTORED: irq_addr = mtvec_base + AW'((IRQ_CAUSE_OFF + int'(arb_idx)) * 4);
      default:        irq_addr = mtvec_base;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cause_d    = cause_q;
    grant_d    = grant_q;
    idx_d      = idx_q;
    is_irq_d   = is_irq_q;
    ptr_d      = ptr_q;
    redirect_d = 1'b0;
    case (state_q)
      ST_REQ: begin
        if (trap_ack_i) begin
          state_d = ST_SERVICE;
          if (is_irq_q) ptr_d = idx_q;
        end
      end
      ST_IDLE, ST_SERVICE: begin
        if ((exception_i != '0) || ecall_i) begin
          state_d  = ST_REQ;
          addr_d   = mtvec_base;
          cause_d  = (exception_i != '0) ? exception_i : AW'(ECALL_CAUSE);
          is_irq_d = 1'b0;
          grant_d  = '0;
        end else if (mret_i) begin
          state_d    = ST_IDLE;
          redirect_d = 1'b1;
          addr_d     = mepc_i;
        end else if ((state_q == ST_IDLE) && mstatus_mie_i && arb_valid) begin
          state_d  = ST_REQ;
          addr_d   = irq_addr;
          cause_d  = irq_cause;
          is_irq_d = 1'b1;
          grant_d  = arb_grant;
          idx_d    = arb_idx;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      irq_q       <= '0;
      irq_prev_q  <= '0;
      edge_pend_q <= '0;
      ptr_q       <= IW'(NUM_SRC - 1);
      idx_q       <= '0;
      grant_q     <= '0;
      addr_q      <= '0;
      cause_q     <= '0;
      is_irq_q    <= 1'b0;
      redirect_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      irq_q       <= irq_i;
      irq_prev_q  <= irq_q;
      edge_pend_q <= edge_pend_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      cause_q     <= cause_d;
      is_irq_q    <= is_irq_d;
      redirect_q  <= redirect_d;
    end
  end

  assign trap_req_o   = (state_q == ST_REQ);
  assign trap_addr_o  = addr_q;
  assign trap_cause_o = cause_q;
  assign redirect_o   = redirect_q;
  assign pending_o    = pending_vec;

endmodule
